bus_master_port: RTL and testbench
==================================

# bus_master_port

Parametrised bus master port connecting one line-granular client (instruction cache, data cache, interrupt controller) to the shared system bus. It accepts a whole-line read or write request from the client and arbitrates for the bus via BR/BG. It then serialises the line into LINE_W/BUS_W data beats with per-beat ACK_IN handshaking, releases the bus and returns a one-cycle ready pulse to the client. It generalises the fixed 128-bit/32-bit cache port with configurable widths, a destination field and an optional transaction watchdog.

## Interface
- LINE_W, 128: client line width in bits; must be an integer multiple of BUS_W.
- BUS_W, 32: bus data width in bits.
- A_W, 16: address width.
- DEST_W, 3: destination-ID width.
- TIMEOUT_CYC, 64: watchdog limit in cycles; used only when the watchdog is compiled in.
- BUS_CLK  in  1  bus clock; all state changes on its rising edge.
- RST  in  1  asynchronous, active-low reset.
- EN  in  1  client request strobe; sampled only in IDLE.
- WR  in  1  1 = write line, 0 = read line.
- A  in  A_W  line address.
- DEST  in  DEST_W  target ID.
- WRITE_DATA  in  LINE_W  line to write.
- READ_DATA  out  LINE_W  assembled read line; holds its value until the next read completes.
- R  out  1  one-cycle done pulse.
- ERR  out  1  qualifies R; 1 = aborted transaction.
- BR  out  1  bus request to arbitrator.
- BG  in  1  bus grant.
- ACK_OUT  out  1  one-cycle bus-release pulse to arbitrator.
- ACK_IN  in  1  target beat acknowledge.
- A_OUT  out  A_W  address-phase address.
- SIZE_OUT  out  12  transfer size in bytes, equal to LINE_W/8.
- RW_OUT  out  1  1 = write.
- DEST_OUT  out  DEST_W  target ID.
- AV_OUT  out  1  address-phase valid.
- D_OUT  out  BUS_W  write beat data.
- D_OE  out  1  data drive enable; the top level muxes or tristates D.
- D_IN  in  BUS_W  read beat data.

## Operation
- States: IDLE, REQ, ADDR, DATA, DONE.
- IDLE: on EN=1, latch WR, A, DEST and WRITE_DATA into the line buffer, clear the beat counter, then go to REQ.
- REQ: BR=1. On BG=1, go to ADDR.
- ADDR: for one cycle, AV_OUT=1 and A_OUT, SIZE_OUT, RW_OUT and DEST_OUT are driven. Then go to DATA.
- DATA, write: D_OE=1 and D_OUT = beat k = line[k*BUS_W +: BUS_W].
- DATA, read: on ACK_IN=1, D_IN is captured into beat k.
- DATA, beat advance: k advances only on a cycle with ACK_IN=1. The ACK on beat NB-1 (NB = LINE_W/BUS_W) moves the FSM to DONE.
- DONE: R=1, ACK_OUT=1 and BR=0 for one cycle. READ_DATA is updated from the buffer for reads. Then go to IDLE.
- BR stays at 1 from REQ through DATA. BG dropping after the grant is ignored; the bus is owned until ACK_OUT.
- EN outside IDLE is ignored and is not queued. The client re-asserts after R.
- ACK_IN outside DATA is ignored.
- Beat counter width is clog2(NB), with a minimum of 1. No wrap occurs because the exit happens at NB-1.
- NB=1 is legal: a single beat goes straight to DONE.
- RST low in any state returns the port to IDLE. Reset values:
  - BR, ACK_OUT, R, ERR, AV_OUT and D_OE are 0.
  - A_OUT, SIZE_OUT, RW_OUT, DEST_OUT, D_OUT and READ_DATA are 0.
  - The beat counter and watchdog are 0.
  - A reset mid-transfer drops BR immediately. There is no partial R.

## Timing
- All outputs are registered except D_OUT and D_OE, which decode from state and beat counter.
- EN at cycle 0 gives BR=1 at cycle 1.
- If BG=1 is sampled at cycle g, the ADDR phase is at cycle g+1 and beat 0 is available at g+2.
- With zero-wait ACK, the last beat is at g+1+NB and R/ACK_OUT are at g+2+NB.
- Each cycle without ACK_IN adds one cycle of latency.
- A new EN is accepted at the earliest one cycle after R.

## Configuration
- BUS_PORT_TIMEOUT_EN
  - Defined: a counter clears on every ACK_IN and on entering REQ, and increments in REQ and DATA. When it reaches TIMEOUT_CYC, the FSM goes to DONE with R=1, ERR=1 and ACK_OUT=1 (ACK_OUT is asserted only if the grant was held). READ_DATA is not updated.
  - Undefined: there is no counter, the FSM waits indefinitely and ERR is tied to 0.

## Structure
- Shared package bus_pkg holds:
  - the state enum;
  - DEST codes DEST_MEM, DEST_IC, DEST_DC, DEST_DMA, DEST_KBD, DEST_INTR;
  - the SIZE_OUT width of 12;
  - a size helper function.
- Sub-module line_beat_buffer (LINE_W, BUS_W) contains:
  - the line register with parallel load;
  - per-beat write/read select;
  - the beat counter, with a last-beat flag as output.

## Test plan
- Write, zero-wait: EN, WR=1, A=16'h0040, WRITE_DATA=128'h...DDDDCCCCBBBBAAAA, BG at cycle 2 -> ADDR at cycle 3 with SIZE_OUT=16; D_OUT = AAAA, BBBB, CCCC, DDDD on cycles 4–7; R and ACK_OUT at cycle 8.
- Read with waits: ACK_IN low for 2 cycles before beat 1, D_IN = 1, 2, 3, 4 -> READ_DATA = {4, 3, 2, 1} per beat; R is delayed by exactly 2 cycles.
- Grant delay and EN while busy: BG withheld for 10 cycles, EN pulsed mid-transaction -> BR stays high; exactly one transaction occurs with one R.
- Reset mid-DATA after beat 1 -> BR=0 at once, all outputs 0, no R; the next EN completes normally.
- Width variant LINE_W=64, BUS_W=64 -> single beat, R at g+3, SIZE_OUT=8.
- With BUS_PORT_TIMEOUT_EN and TIMEOUT_CYC=8: ACK_IN never asserted -> R=1 and ERR=1 eight cycles after the last activity, READ_DATA unchanged, and the port returns to IDLE.

Source files
------------

// File: rtl/bus_pkg.sv
// bus_pkg: shared types and constants for the system-bus master port.
// Latency: n/a (types, constants and a constant function only).
// Backpressure: n/a.
package bus_pkg;

  // Transaction phases of the master port
  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_REQ  = 3'd1,
    ST_ADDR = 3'd2,
    ST_DATA = 3'd3,
    ST_DONE = 3'd4
  } state_t;

  // Width of the SIZE_OUT field (bytes per transfer)
  localparam int SIZE_W = 12;

  // Destination IDs on the system bus
  localparam logic [2:0] DEST_MEM  = 3'd0;
  localparam logic [2:0] DEST_IC   = 3'd1;
  localparam logic [2:0] DEST_DC   = 3'd2;
  localparam logic [2:0] DEST_DMA  = 3'd3;
  localparam logic [2:0] DEST_KBD  = 3'd4;
  localparam logic [2:0] DEST_INTR = 3'd5;

  // Transfer size in bytes for a line of line_w bits
  function automatic logic [SIZE_W-1:0] line_bytes(input int line_w);
    return SIZE_W'(line_w / 8);
  endfunction

endpackage

// File: rtl/line_beat_buffer.sv
// line_beat_buffer: line register split into BUS_W beats with a beat counter and last-beat flag.
// Latency: load/capture/advance take effect on the next clock; beat select and merged line are combinational.
// Backpressure: none of its own; the counter only moves when adv is asserted by the owner.
module line_beat_buffer #(
  parameter int LINE_W = 128,
  parameter int BUS_W  = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              load,
  input  logic [LINE_W-1:0] load_dat,
  input  logic              adv,
  input  logic              capture,
  input  logic [BUS_W-1:0]  beat_in,
  output logic [BUS_W-1:0]  beat_out,
  output logic [LINE_W-1:0] line_mrg,
  output logic              last_beat
);

  localparam int NB    = LINE_W / BUS_W;
  localparam int CNT_W = (NB > 1) ? $clog2(NB) : 1;

  logic [LINE_W-1:0] line_q;
  logic [CNT_W-1:0]  beat_q;

  // The exit happens on beat NB-1, so the counter never needs to wrap
  assign last_beat = (beat_q == CNT_W'(NB - 1));

  // Select the current beat, and form the line with the current beat replaced by beat_in
  always_comb begin
    beat_out = '0;
    line_mrg = line_q;
    for (int k = 0; k < NB; k++) begin
      if (beat_q == CNT_W'(k)) begin
        beat_out                  = line_q[k*BUS_W +: BUS_W];
        line_mrg[k*BUS_W +: BUS_W] = beat_in;
      end
    end
  end

  // Line register: parallel load of a client line, or capture of one read beat
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      line_q <= '0;
    end else if (load) begin
      line_q <= load_dat;
    end else if (capture) begin
      line_q <= line_mrg;
    end
  end

  // Beat counter: cleared by a new line, advanced per acknowledged beat
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      beat_q <= '0;
    end else if (load) begin
      beat_q <= '0;
    end else if (adv && !last_beat) begin
      beat_q <= beat_q + CNT_W'(1);
    end
  end

endmodule

// File: rtl/bus_master_port.sv
// bus_master_port: arbitrates via BR/BG and moves one client line to/from the bus as LINE_W/BUS_W beats.
// Latency: EN->BR 1 cycle; BG at g -> ADDR g+1, beat 0 at g+2, R/ACK_OUT at g+2+NB with zero-wait ACK_IN.
// Backpressure: each beat waits for ACK_IN; EN is taken only in IDLE. Watchdog macro: BUS_PORT_TIMEOUT_EN.
module bus_master_port
  import bus_pkg::*;
#(
  parameter int LINE_W      = 128,
  parameter int BUS_W       = 32,
  parameter int A_W         = 16,
  parameter int DEST_W      = 3,
  parameter int TIMEOUT_CYC = 64
) (
  input  logic              BUS_CLK,
  input  logic              RST,
  input  logic              EN,
  input  logic              WR,
  input  logic [A_W-1:0]    A,
  input  logic [DEST_W-1:0] DEST,
  input  logic [LINE_W-1:0] WRITE_DATA,
  output logic [LINE_W-1:0] READ_DATA,
  output logic              R,
  output logic              ERR,
  output logic              BR,
  input  logic              BG,
  output logic              ACK_OUT,
  input  logic              ACK_IN,
  output logic [A_W-1:0]    A_OUT,
  output logic [SIZE_W-1:0] SIZE_OUT,
  output logic              RW_OUT,
  output logic [DEST_W-1:0] DEST_OUT,
  output logic              AV_OUT,
  output logic [BUS_W-1:0]  D_OUT,
  output logic              D_OE,
  input  logic [BUS_W-1:0]  D_IN
);

  localparam logic [SIZE_W-1:0] LINE_SIZE = line_bytes(LINE_W);

  state_t             state_q;
  state_t             state_d;
  logic               wr_q;
  logic [A_W-1:0]     addr_q;
  logic [DEST_W-1:0]  dest_q;

  logic               buf_load;
  logic               buf_adv;
  logic               buf_capture;
  logic               last_beat;
  logic [BUS_W-1:0]   beat_out;
  logic [LINE_W-1:0]  line_mrg;

  logic               abort;
  logic               wd_expire;

  line_beat_buffer #(
    .LINE_W (LINE_W),
    .BUS_W  (BUS_W)
  ) u_buf (
    .clk       (BUS_CLK),
    .rst_n     (RST),
    .load      (buf_load),
    .load_dat  (WRITE_DATA),
    .adv       (buf_adv),
    .capture   (buf_capture),
    .beat_in   (D_IN),
    .beat_out  (beat_out),
    .line_mrg  (line_mrg),
    .last_beat (last_beat)
  );

`ifdef BUS_PORT_TIMEOUT_EN
  localparam int WD_W = $clog2(TIMEOUT_CYC + 1);

  logic [WD_W-1:0] wd_q;
  logic            wd_run;

  // Counts REQ and DATA cycles; any ACK_IN restarts it
  assign wd_run    = (state_q == ST_REQ) || (state_q == ST_DATA);
  assign wd_expire = wd_run && !((state_q == ST_DATA) && ACK_IN) &&
                     (wd_q == WD_W'(TIMEOUT_CYC - 1));

  // Watchdog: cleared on entry to REQ and on each beat acknowledge, frozen elsewhere
  always_ff @(posedge BUS_CLK or negedge RST) begin
    if (!RST) begin
      wd_q <= '0;
    end else if ((state_q == ST_IDLE) && EN) begin
      wd_q <= '0;
    end else if ((state_q == ST_DATA) && ACK_IN) begin
      wd_q <= '0;
    end else if (wd_run) begin
      wd_q <= wd_q + WD_W'(1);
    end
  end
`else
  // No watchdog: the port waits for BG and ACK_IN indefinitely (TIMEOUT_CYC is never negative)
  assign wd_expire = (TIMEOUT_CYC < 0);
`endif

  // Beat data is driven straight from the buffer while writing
  assign D_OE  = (state_q == ST_DATA) && wr_q;
  assign D_OUT = D_OE ? beat_out : '0;

  // State register
  always_ff @(posedge BUS_CLK or negedge RST) begin
    if (!RST) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next state and buffer controls
  always_comb begin
    state_d     = state_q;
    buf_load    = 1'b0;
    buf_adv     = 1'b0;
    buf_capture = 1'b0;
    abort       = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (EN) begin
          buf_load = 1'b1;
          state_d  = ST_REQ;
        end
      end
      ST_REQ: begin
        if (BG) begin
          state_d = ST_ADDR;
        end else if (wd_expire) begin
          abort   = 1'b1;
          state_d = ST_DONE;
        end
      end
      ST_ADDR: begin
        state_d = ST_DATA;
      end
      ST_DATA: begin
        if (ACK_IN) begin
          buf_adv     = 1'b1;
          buf_capture = !wr_q;
          if (last_beat) begin
            state_d = ST_DONE;
          end
        end else if (wd_expire) begin
          abort   = 1'b1;
          state_d = ST_DONE;
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Request attributes held for the whole transaction
  always_ff @(posedge BUS_CLK or negedge RST) begin
    if (!RST) begin
      wr_q   <= 1'b0;
      addr_q <= '0;
      dest_q <= '0;
    end else if (buf_load) begin
      wr_q   <= WR;
      addr_q <= A;
      dest_q <= DEST;
    end
  end

  // Registered bus/client outputs, decoded from the state being entered
  always_ff @(posedge BUS_CLK or negedge RST) begin
    if (!RST) begin
      BR        <= 1'b0;
      AV_OUT    <= 1'b0;
      A_OUT     <= '0;
      SIZE_OUT  <= '0;
      RW_OUT    <= 1'b0;
      DEST_OUT  <= '0;
      R         <= 1'b0;
      ERR       <= 1'b0;
      ACK_OUT   <= 1'b0;
      READ_DATA <= '0;
    end else begin
      BR       <= (state_d == ST_REQ) || (state_d == ST_ADDR) || (state_d == ST_DATA);
      AV_OUT   <= (state_d == ST_ADDR);
      A_OUT    <= (state_d == ST_ADDR) ? addr_q : '0;
      SIZE_OUT <= (state_d == ST_ADDR) ? LINE_SIZE : '0;
      RW_OUT   <= (state_d == ST_ADDR) && wr_q;
      DEST_OUT <= (state_d == ST_ADDR) ? dest_q : '0;
      R        <= (state_d == ST_DONE);
      ERR      <= (state_d == ST_DONE) && abort;
      // A timeout in REQ never owned the bus, so there is nothing to release
      ACK_OUT  <= (state_d == ST_DONE) && (!abort || (state_q == ST_DATA));
      // line_mrg already carries the final beat arriving on this edge
      if ((state_d == ST_DONE) && !abort && !wr_q) begin
        READ_DATA <= line_mrg;
      end
    end
  end

endmodule

// File: tb/tb_bus_master_port.sv
// tb_bus_master_port: randomized transactions against a transaction-level scoreboard.
// Latency: expectations derived from BG/ACK_IN timing rules of the port.
// Backpressure: bench plays arbiter and target, withholding BG and ACK_IN at random.
module tb_bus_master_port;

  localparam int LW  = 128;
  localparam int BW  = 32;
  localparam int NB  = LW / BW;
  localparam int LW2 = 64;
  localparam int BW2 = 64;
  localparam int TO2 = 8;

  logic bus_clk = 1'b0;
  always #5 bus_clk = ~bus_clk;

  logic rst_n;

  logic          en, wr_i, bg, ack_in, r, err, br, ack_out, rw_out, av_out, d_oe;
  logic [15:0]   a, a_out;
  logic [2:0]    dest, dest_out;
  logic [127:0]  write_data, read_data;
  logic [11:0]   size_out;
  logic [31:0]   d_out, d_in;

  logic          en2, wr2, bg2, ack2, r2, err2, br2, ack_out2, rw_out2, av_out2, d_oe2;
  logic [15:0]   a2, a_out2;
  logic [2:0]    dest2, dest_out2;
  logic [63:0]   write_data2, read_data2, d_out2, d_in2;
  logic [11:0]   size_out2;

  bus_master_port #(.LINE_W(LW), .BUS_W(BW), .A_W(16), .DEST_W(3), .TIMEOUT_CYC(64)) dut (
    .BUS_CLK(bus_clk), .RST(rst_n), .EN(en), .WR(wr_i), .A(a), .DEST(dest),
    .WRITE_DATA(write_data), .READ_DATA(read_data), .R(r), .ERR(err), .BR(br), .BG(bg),
    .ACK_OUT(ack_out), .ACK_IN(ack_in), .A_OUT(a_out), .SIZE_OUT(size_out), .RW_OUT(rw_out),
    .DEST_OUT(dest_out), .AV_OUT(av_out), .D_OUT(d_out), .D_OE(d_oe), .D_IN(d_in)
  );

  bus_master_port #(.LINE_W(LW2), .BUS_W(BW2), .A_W(16), .DEST_W(3), .TIMEOUT_CYC(TO2)) dut2 (
    .BUS_CLK(bus_clk), .RST(rst_n), .EN(en2), .WR(wr2), .A(a2), .DEST(dest2),
    .WRITE_DATA(write_data2), .READ_DATA(read_data2), .R(r2), .ERR(err2), .BR(br2), .BG(bg2),
    .ACK_OUT(ack_out2), .ACK_IN(ack2), .A_OUT(a_out2), .SIZE_OUT(size_out2), .RW_OUT(rw_out2),
    .DEST_OUT(dest_out2), .AV_OUT(av_out2), .D_OUT(d_out2), .D_OE(d_oe2), .D_IN(d_in2)
  );

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;
  logic [127:0] exp_rd  = '0;
  logic [63:0]  exp_rd2 = '0;

  task automatic check_eq(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge bus_clk);
    #1;
    cyc++;
  endtask

  // One line transaction on the 128/32 port. ack_pct < 0 selects the directed ack_pat
  // with D_IN = beat number + 1. rst_beat >= 0 resets the port once that beat is acknowledged.
  task automatic run_txn(input logic wr, input logic [15:0] addr, input logic [2:0] dst,
                         input logic [127:0] line, input int gdly, input int ack_pct,
                         input bit busy_en, input int rst_beat, input logic [31:0] ack_pat);
    int g, k, waits, guard;
    logic ack;
    logic [31:0]  exp_beat;
    logic [127:0] rd_line;
    rd_line = '0;
    en = 1'b1; wr_i = wr; a = addr; dest = dst; write_data = line; bg = 1'b0; ack_in = 1'b0;
    tick();
    // scramble client inputs: the port must have latched them
    en = 1'b0; wr_i = 1'($urandom); a = 16'($urandom); dest = 3'($urandom);
    write_data = {$urandom(), $urandom(), $urandom(), $urandom()};
    check_eq("br_rise", br, 1'b1);
    for (int i = 0; i < gdly; i++) begin
      bg = 1'b0;
      ack_in = 1'($urandom_range(0, 1));
      en = busy_en && (i == gdly / 2);
      tick();
      check_eq("br_hold_req", br, 1'b1);
      check_eq("av_early", av_out, 1'b0);
    end
    en = 1'b0; bg = 1'b1; ack_in = 1'($urandom_range(0, 1));
    g = cyc;
    tick();
    check_eq("av_out", av_out, 1'b1);
    check_eq("a_out", a_out, addr);
    check_eq("size_out", size_out, 12'(LW / 8));
    check_eq("rw_out", rw_out, wr);
    check_eq("dest_out", dest_out, dst);
    check_eq("br_addr", br, 1'b1);
    bg = 1'($urandom_range(0, 1));
    ack_in = 1'($urandom_range(0, 1));
    tick();
    k = 0; waits = 0; guard = 0;
    while (k < NB && guard < 200) begin
      if (ack_pct < 0) begin
        ack = ack_pat[guard];
        d_in = 32'(k + 1);
      end else begin
        ack = ($urandom_range(0, 99) < ack_pct);
        d_in = $urandom();
      end
      ack_in = ack;
      bg = 1'($urandom_range(0, 1));
      check_eq("d_oe", d_oe, wr);
      if (wr) begin
        exp_beat = line[k*BW +: BW];
        check_eq("d_out", d_out, exp_beat);
      end
      check_eq("r_early", r, 1'b0);
      check_eq("br_data", br, 1'b1);
      if (ack) begin
        rd_line[k*BW +: BW] = d_in;
        k++;
      end else begin
        waits++;
      end
      guard++;
      tick();
      if (rst_beat >= 0 && k > rst_beat) begin
        ack_in = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        exp_rd = '0;
        exp_rd2 = '0;
        check_eq("rst_br", br, 1'b0);
        check_eq("rst_r", r, 1'b0);
        check_eq("rst_ack_out", ack_out, 1'b0);
        check_eq("rst_av", av_out, 1'b0);
        check_eq("rst_d_oe", d_oe, 1'b0);
        check_eq("rst_d_out", d_out, 32'h0);
        check_eq("rst_a_out", a_out, 16'h0);
        check_eq("rst_read_data", read_data, exp_rd);
        tick();
        check_eq("rst_no_r", r, 1'b0);
        rst_n = 1'b1;
        tick();
        check_eq("rst_idle_br", br, 1'b0);
        check_eq("rst_idle_r", r, 1'b0);
        return;
      end
    end
    check_eq("beats_done", k, NB);
    ack_in = 1'b0; bg = 1'b0;
    if (!wr) exp_rd = rd_line;
    check_eq("r_pulse", r, 1'b1);
    check_eq("ack_out", ack_out, 1'b1);
    check_eq("err", err, 1'b0);
    check_eq("br_released", br, 1'b0);
    check_eq("r_latency", cyc - g, NB + 2 + waits);
    check_eq("read_data", read_data, exp_rd);
    tick();
    check_eq("r_one_cycle", r, 1'b0);
    check_eq("ack_out_one_cycle", ack_out, 1'b0);
    if (busy_en) begin
      for (int i = 0; i < 3; i++) begin
        tick();
        check_eq("busy_en_not_queued", br, 1'b0);
      end
    end
  endtask

  // Single-beat transaction on the 64/64 port, grant and ack with no wait
  task automatic run_one2(input logic wr, input logic [63:0] line);
    int g;
    logic [63:0] din;
    din = {$urandom(), $urandom()};
    en2 = 1'b1; wr2 = wr; a2 = 16'h1230; dest2 = 3'd4; write_data2 = line; bg2 = 1'b0; ack2 = 1'b0;
    tick();
    en2 = 1'b0; write_data2 = '0;
    check_eq("w2_br", br2, 1'b1);
    bg2 = 1'b1;
    g = cyc;
    tick();
    bg2 = 1'b0;
    check_eq("w2_av", av_out2, 1'b1);
    check_eq("w2_size", size_out2, 12'(LW2 / 8));
    check_eq("w2_a_out", a_out2, 16'h1230);
    check_eq("w2_rw", rw_out2, wr);
    check_eq("w2_dest", dest_out2, 3'd4);
    tick();
    check_eq("w2_d_oe", d_oe2, wr);
    if (wr) check_eq("w2_d_out", d_out2, line);
    ack2 = 1'b1; d_in2 = din;
    tick();
    ack2 = 1'b0;
    if (!wr) exp_rd2 = din;
    check_eq("w2_r", r2, 1'b1);
    check_eq("w2_ack_out", ack_out2, 1'b1);
    check_eq("w2_err", err2, 1'b0);
    check_eq("w2_latency", cyc - g, 3);
    check_eq("w2_read_data", read_data2, exp_rd2);
    tick();
    check_eq("w2_r_one_cycle", r2, 1'b0);
  endtask

`ifdef BUS_PORT_TIMEOUT_EN
  // Read that is never acknowledged: R/ERR once TO2 REQ/DATA cycles have elapsed since the last clear
  task automatic wd2(input bit grant);
    int cnt, guard;
    en2 = 1'b1; wr2 = 1'b0; a2 = 16'h0777; dest2 = 3'd1; bg2 = 1'b0; ack2 = 1'b0;
    tick();
    en2 = 1'b0;
    cnt = 0;
    if (grant) begin
      bg2 = 1'b1;
      tick();
      bg2 = 1'b0;
      cnt = 1;
      tick();
    end
    guard = 0;
    while (!r2 && guard < 60) begin
      tick();
      cnt++;
      guard++;
    end
    check_eq("wd_cycles", cnt, TO2);
    check_eq("wd_err", err2, 1'b1);
    check_eq("wd_ack_out", ack_out2, grant);
    check_eq("wd_read_data", read_data2, exp_rd2);
    check_eq("wd_br", br2, 1'b0);
    tick();
    check_eq("wd_r_one_cycle", r2, 1'b0);
    check_eq("wd_err_clear", err2, 1'b0);
  endtask
`endif

  initial begin
    rst_n = 1'b0;
    en = 1'b0; wr_i = 1'b0; a = '0; dest = '0; write_data = '0; bg = 1'b0; ack_in = 1'b0; d_in = '0;
    en2 = 1'b0; wr2 = 1'b0; a2 = '0; dest2 = '0; write_data2 = '0; bg2 = 1'b0; ack2 = 1'b0; d_in2 = '0;
    repeat (3) @(posedge bus_clk);
    #1;
    check_eq("reset_br", br, 1'b0);
    check_eq("reset_r", r, 1'b0);
    check_eq("reset_err", err, 1'b0);
    check_eq("reset_ack_out", ack_out, 1'b0);
    check_eq("reset_av", av_out, 1'b0);
    check_eq("reset_d_oe", d_oe, 1'b0);
    check_eq("reset_a_out", a_out, 16'h0);
    check_eq("reset_size", size_out, 12'h0);
    check_eq("reset_rw", rw_out, 1'b0);
    check_eq("reset_dest", dest_out, 3'h0);
    check_eq("reset_d_out", d_out, 32'h0);
    check_eq("reset_read_data", read_data, 128'h0);
    check_eq("reset2_br", br2, 1'b0);
    check_eq("reset2_read_data", read_data2, 64'h0);
    rst_n = 1'b1;
    tick();

    // zero-wait write, BG at cycle 2
    run_txn(1'b1, 16'h0040, 3'd0, 128'h0000DDDD_0000CCCC_0000BBBB_0000AAAA, 1, 100, 1'b0, -1, 32'h0);
    // read with two wait cycles before beat 1, D_IN = 1,2,3,4
    run_txn(1'b0, 16'h0100, 3'd2, 128'h0, 0, -1, 1'b0, -1, 32'b111001);
    check_eq("read_line_const", read_data, 128'h00000004_00000003_00000002_00000001);
    // grant withheld for 10 cycles with a stray EN while busy
    run_txn(1'b1, 16'h2222, 3'd3, {$urandom(), $urandom(), $urandom(), $urandom()}, 10, 100, 1'b1, -1, 32'h0);
    // reset once beat 1 has been acknowledged, then a normal transfer
    run_txn(1'b0, 16'h3330, 3'd1, 128'h0, 2, 100, 1'b0, 1, 32'h0);
    run_txn(1'b0, 16'h4440, 3'd5, 128'h0, 1, 100, 1'b0, -1, 32'h0);

    for (int t = 0; t < 25; t++) begin
      run_txn(1'($urandom_range(0, 1)), 16'($urandom()), 3'($urandom_range(0, 5)),
              {$urandom(), $urandom(), $urandom(), $urandom()},
              $urandom_range(0, 6), $urandom_range(40, 100), 1'b0, -1, 32'h0);
      repeat ($urandom_range(0, 2)) tick();
    end

    run_one2(1'b1, {$urandom(), $urandom()});
    run_one2(1'b0, 64'h0);
    run_one2(1'b0, 64'h0);
`ifdef BUS_PORT_TIMEOUT_EN
    wd2(1'b1);
    wd2(1'b0);
    run_one2(1'b0, 64'h0);
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
